// File: rtl/biriscv_ifetch_mem_responder_pkg.sv
//------------------------------------------------------------------------------
// biriscv_ifetch_mem_responder_pkg
//
// Shared definitions for the cacheless instruction-fetch responder:
//   - 3-bit state encoding of the responder FSM
//   - privilege level constants carried on the fetch interface
//------------------------------------------------------------------------------
package biriscv_ifetch_mem_responder_pkg;

   // Raw state encodings, kept as plain constants so other blocks and
   // debug logic can decode the state bus without the enum type.
   localparam logic [2:0] STATE_IDLE    = 3'd0;
   localparam logic [2:0] STATE_LO_REQ  = 3'd1;
   localparam logic [2:0] STATE_LO_WAIT = 3'd2;
   localparam logic [2:0] STATE_HI_REQ  = 3'd3;
   localparam logic [2:0] STATE_HI_WAIT = 3'd4;
   localparam logic [2:0] STATE_RESP    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = STATE_IDLE,
      ST_LO_REQ  = STATE_LO_REQ,
      ST_LO_WAIT = STATE_LO_WAIT,
      ST_HI_REQ  = STATE_HI_REQ,
      ST_HI_WAIT = STATE_HI_WAIT,
      ST_RESP    = STATE_RESP
   } state_t;

   // Privilege levels as presented on icache_priv_i.
   localparam logic [1:0] PRIV_USER    = 2'd0;
   localparam logic [1:0] PRIV_SUPER   = 2'd1;
   localparam logic [1:0] PRIV_MACHINE = 2'd3;

endpackage

// File: rtl/biriscv_ifetch_mem_responder.sv
//------------------------------------------------------------------------------
// biriscv_ifetch_mem_responder
//
// Responder end of the fetch-to-icache interface for cacheless builds.
// Each accepted 64-bit fetch is served as two sequential 32-bit reads on a
// simple memory port (low word, then high word) and returned as a single
// one-cycle response {hi_word, lo_word}. Fetches outside the mapped region
// are answered with an error and no memory access.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   icache_rd_i            fetch request (taken when icache_accept_o is high)
//   icache_pc_i            fetch byte address, bits [2:0] ignored
//   icache_priv_i          privilege level (unused, no MMU)
//   icache_flush_i         flush (no state to flush, ignored)
//   icache_invalidate_i    invalidate (no state to invalidate, ignored)
//   icache_accept_o        request can be taken this cycle
//   icache_valid_o         one-cycle response pulse
//   icache_inst_o          response data {hi, lo}, zero when not valid
//   icache_error_o         range or bus error, zero when not valid
//   icache_page_fault_o    tied low
//   mem_rd_o, mem_addr_o   32-bit read request and word-aligned byte address
//   mem_accept_i           memory took the request
//   mem_ack_i, mem_data_i  read data return
//   mem_error_i            bus error, qualified by mem_ack_i
//------------------------------------------------------------------------------
module biriscv_ifetch_mem_responder
   import biriscv_ifetch_mem_responder_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        icache_rd_i,
   input  logic [31:0] icache_pc_i,
   input  logic [1:0]  icache_priv_i,
   input  logic        icache_flush_i,
   input  logic        icache_invalidate_i,
   output logic        icache_accept_o,
   output logic        icache_valid_o,
   output logic [63:0] icache_inst_o,
   output logic        icache_error_o,
   output logic        icache_page_fault_o,

   output logic        mem_rd_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_accept_i,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   input  logic        mem_error_i
);

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic        err_q;

   logic        take;
   logic [31:0] pc_d;
   logic [32:0] pc_off;
   logic        in_range;
   logic        lo_rd;
   logic        hi_rd;

   // Privilege, flush, invalidate and the sub-doubleword PC bits have no
   // effect in a cacheless, MMU-less responder.
   logic unused_inputs;
   assign unused_inputs = ^{icache_priv_i, icache_flush_i,
                            icache_invalidate_i, icache_pc_i[2:0]};

   //---------------------------------------------------------------------------
   // Request side
   //---------------------------------------------------------------------------
   // Accepting in RESP lets a new fetch be captured while the previous
   // response is on the bus, so a streaming fetch stage sees no accept gap.
   assign icache_accept_o = (state_q == ST_IDLE) | (state_q == ST_RESP);
   assign take            = icache_rd_i & icache_accept_o;
   assign pc_d            = {icache_pc_i[31:3], 3'b000};

   // Range check on the captured PC. The 33-bit subtract doubles as the
   // pc_q >= MEM_BASE test: bit 32 is the borrow.
   assign pc_off   = {1'b0, pc_q} - {1'b0, MEM_BASE};
   assign in_range = ~pc_off[32] & (pc_off[31:0] < MEM_SIZE);

   //---------------------------------------------------------------------------
   // Memory side
   //---------------------------------------------------------------------------
   // The range decision is made from pc_q in LO_REQ; an out-of-range fetch
   // never raises mem_rd_o and leaves LO_REQ straight for RESP.
   assign lo_rd      = (state_q == ST_LO_REQ) & in_range;
   assign hi_rd      = (state_q == ST_HI_REQ);
   assign mem_rd_o   = lo_rd | hi_rd;
   // pc_q is 8-byte aligned and the region is 8-byte granular, so pc_q + 4
   // stays inside the region (wraps mod 2^32 only at the very top).
   assign mem_addr_o = lo_rd ? pc_q : (hi_rd ? (pc_q + 32'd4) : 32'h0);

   //---------------------------------------------------------------------------
   // Response side
   //---------------------------------------------------------------------------
   assign icache_valid_o      = (state_q == ST_RESP);
   assign icache_inst_o       = icache_valid_o ? {hi_q, lo_q} : 64'h0;
   assign icache_error_o      = icache_valid_o & err_q;
   assign icache_page_fault_o = 1'b0;

   //---------------------------------------------------------------------------
   // FSM and datapath registers
   //---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the data registers are few and cheap, so they are reset
         // along with the control state; nothing stale is ever observable.
         state_q <= ST_IDLE;
         pc_q    <= 32'h0;
         lo_q    <= 32'h0;
         hi_q    <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_RESP: begin
               if (take) begin
                  pc_q    <= pc_d;
                  lo_q    <= 32'h0;
                  hi_q    <= 32'h0;
                  err_q   <= 1'b0;
                  state_q <= ST_LO_REQ;
               end else begin
                  // A response is presented for exactly one cycle.
                  state_q <= ST_IDLE;
               end
            end

            ST_LO_REQ: begin
               if (!in_range) begin
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else if (mem_accept_i) begin
                  state_q <= ST_LO_WAIT;
               end
            end

            ST_LO_WAIT: begin
               if (mem_ack_i) begin
                  lo_q    <= mem_data_i;
                  err_q   <= err_q | mem_error_i;
                  // The high read is always issued, even after a low-word
                  // error, so the memory port never sees a half transaction.
                  state_q <= ST_HI_REQ;
               end
            end

            ST_HI_REQ: begin
               if (mem_accept_i) begin
                  state_q <= ST_HI_WAIT;
               end
            end

            ST_HI_WAIT: begin
               if (mem_ack_i) begin
                  hi_q    <= mem_data_i;
                  err_q   <= err_q | mem_error_i;
                  state_q <= ST_RESP;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_biriscv_ifetch_mem_responder.sv
//------------------------------------------------------------------------------
// Directed bench for biriscv_ifetch_mem_responder with a small memory model
// (per-word accept stall, ack delay and error injection).
//------------------------------------------------------------------------------
module tb_biriscv_ifetch_mem_responder;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        icache_rd_i = 1'b0;
   logic [31:0] icache_pc_i = 32'h0;
   logic [1:0]  icache_priv_i = 2'd3;
   logic        icache_flush_i = 1'b0;
   logic        icache_invalidate_i = 1'b0;
   logic        icache_accept_o;
   logic        icache_valid_o;
   logic [63:0] icache_inst_o;
   logic        icache_error_o;
   logic        icache_page_fault_o;
   logic        mem_rd_o;
   logic [31:0] mem_addr_o;
   logic        mem_accept_i = 1'b0;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_data_i = 32'h0;
   logic        mem_error_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   biriscv_ifetch_mem_responder #(
      .MEM_BASE (32'h0000_0000),
      .MEM_SIZE (32'h0001_0000)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .icache_rd_i         (icache_rd_i),
      .icache_pc_i         (icache_pc_i),
      .icache_priv_i       (icache_priv_i),
      .icache_flush_i      (icache_flush_i),
      .icache_invalidate_i (icache_invalidate_i),
      .icache_accept_o     (icache_accept_o),
      .icache_valid_o      (icache_valid_o),
      .icache_inst_o       (icache_inst_o),
      .icache_error_o      (icache_error_o),
      .icache_page_fault_o (icache_page_fault_o),
      .mem_rd_o            (mem_rd_o),
      .mem_addr_o          (mem_addr_o),
      .mem_accept_i        (mem_accept_i),
      .mem_ack_i           (mem_ack_i),
      .mem_data_i          (mem_data_i),
      .mem_error_i         (mem_error_i)
   );

   always #5 clk = ~clk;

   //---------------------------------------------------------------------------
   // Memory model: runs on the falling edge, DUT outputs are stable there.
   // Index 0 = low word (addr[2]=0), index 1 = high word (addr[2]=1).
   //---------------------------------------------------------------------------
   logic [31:0] mem_arr [64];
   int          cfg_acc_stall [2] = '{0, 0};
   int          cfg_ack_delay [2] = '{0, 0};
   bit          cfg_err [2] = '{1'b0, 1'b0};

   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          ack_wait = 0;
   int          stall_seen = 0;
   logic [31:0] addr_log [$];
   int          rd_cycles = 0;

   always @(negedge clk) begin
      mem_ack_i    = 1'b0;
      mem_data_i   = 32'h0;
      mem_error_i  = 1'b0;
      mem_accept_i = 1'b0;
      if (rst_i) begin
         pend       = 1'b0;
         stall_seen = 0;
      end else begin
         if (pend) begin
            if (ack_wait == 0) begin
               mem_ack_i   = 1'b1;
               mem_data_i  = mem_arr[pend_addr[7:2]];
               mem_error_i = cfg_err[pend_addr[2]];
               pend        = 1'b0;
            end else begin
               ack_wait--;
            end
         end
         if (mem_rd_o) begin
            rd_cycles++;
            if (!pend) begin
               if (stall_seen < cfg_acc_stall[mem_addr_o[2]]) begin
                  stall_seen++;
               end else begin
                  mem_accept_i = 1'b1;
                  stall_seen   = 0;
                  pend         = 1'b1;
                  pend_addr    = mem_addr_o;
                  ack_wait     = cfg_ack_delay[mem_addr_o[2]];
                  addr_log.push_back(mem_addr_o);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Presents a fetch in the current (accepting) cycle and waits for valid.
   // lat = cycles from take to valid (-1 on timeout); acc_hi counts cycles
   // with accept high before the response.
   task automatic issue_and_wait(input logic [31:0] pc, input int flush_at,
                                 output int lat, output int acc_hi);
      icache_rd_i = 1'b1;
      icache_pc_i = pc;
      lat    = -1;
      acc_hi = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         icache_rd_i         = 1'b0;
         icache_flush_i      = (k == flush_at);
         icache_invalidate_i = (k == flush_at);
         if (icache_valid_o) begin
            lat = k;
            break;
         end
         if (icache_accept_o) acc_hi++;
      end
      icache_flush_i      = 1'b0;
      icache_invalidate_i = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      vectors++;
      if (icache_accept_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_accept: got %b expected 1", icache_accept_o);
      end
      vectors++;
      if ({icache_valid_o, icache_error_o, icache_page_fault_o, mem_rd_o} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {icache_valid_o, icache_error_o, icache_page_fault_o, mem_rd_o});
      end
      vectors++;
      if ({icache_inst_o, mem_addr_o} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_data: got inst %h addr %h expected 0", icache_inst_o, mem_addr_o);
      end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat, acc, n0;
      n0 = addr_log.size();
      issue_and_wait(32'h0000_0004, 0, lat, acc);
      vectors++;
      if (lat !== 5) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d expected 5", lat);
      end
      vectors++;
      if (icache_inst_o !== 64'h00100093_00000013 || icache_error_o !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_data: got %h err %b expected 00100093_00000013 err 0",
                  icache_inst_o, icache_error_o);
      end
      vectors++;
      if (addr_log.size() !== n0 + 2 || addr_log[n0] !== 32'h0 || addr_log[n0+1] !== 32'h4) begin
         miscompares++;
         $display("FAIL basic_addrs: got %0d reads expected 2 at 0 then 4", addr_log.size() - n0);
      end
      tick();
      vectors++;
      if (icache_valid_o !== 1'b0 || icache_inst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL basic_pulse: got valid %b inst %h expected 0 and 0", icache_valid_o, icache_inst_o);
      end
      tick();
   endtask

   task automatic test_top_of_region();
      int lat, acc, n0;
      n0 = addr_log.size();
      issue_and_wait(32'h0000_FFFC, 0, lat, acc);
      vectors++;
      if (lat !== 5 || icache_inst_o !== 64'hCAFE0002_CAFE0001 || icache_error_o !== 1'b0) begin
         miscompares++;
         $display("FAIL top_region: got lat %0d inst %h err %b expected 5 CAFE0002_CAFE0001 0",
                  lat, icache_inst_o, icache_error_o);
      end
      vectors++;
      if (addr_log.size() !== n0 + 2 || addr_log[n0] !== 32'hFFF8 || addr_log[n0+1] !== 32'hFFFC) begin
         miscompares++;
         $display("FAIL top_region_addrs: got %0d reads expected 2 at FFF8 then FFFC", addr_log.size() - n0);
      end
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int first, second, n0;
      logic [63:0] inst1, inst2;
      logic acc_at_first;
      first = -1;
      second = -1;
      inst1 = 64'h0;
      inst2 = 64'h0;
      acc_at_first = 1'b0;
      n0 = addr_log.size();
      icache_rd_i = 1'b1;
      icache_pc_i = 32'h0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 1) icache_pc_i = 32'h8;
         if (icache_valid_o) begin
            if (first < 0) begin
               first = k;
               inst1 = icache_inst_o;
               acc_at_first = icache_accept_o;
            end else if (second < 0) begin
               second = k;
               inst2 = icache_inst_o;
            end
         end
         if (first > 0 && k > first) icache_rd_i = 1'b0;
      end
      icache_rd_i = 1'b0;
      vectors++;
      if (first !== 5 || second !== 10) begin
         miscompares++;
         $display("FAIL b2b_timing: got pulses at %0d and %0d expected 5 and 10", first, second);
      end
      vectors++;
      if (acc_at_first !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept: got %b in first response cycle expected 1", acc_at_first);
      end
      vectors++;
      if (inst1 !== 64'h00100093_00000013 || inst2 !== 64'hFFF00113_00002083) begin
         miscompares++;
         $display("FAIL b2b_data: got %h / %h expected 00100093_00000013 / FFF00113_00002083",
                  inst1, inst2);
      end
      vectors++;
      if (addr_log.size() !== n0 + 4 || addr_log[n0+2] !== 32'h8 || addr_log[n0+3] !== 32'hC) begin
         miscompares++;
         $display("FAIL b2b_addrs: got %0d reads expected 4 ending 8, C", addr_log.size() - n0);
      end
      tick();
   endtask

   task automatic test_out_of_range();
      int lat, acc, n0, r0;
      n0 = addr_log.size();
      r0 = rd_cycles;
      issue_and_wait(32'h0001_0000, 0, lat, acc);
      vectors++;
      if (lat !== 2 || icache_error_o !== 1'b1 || icache_inst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL oor_resp: got lat %0d err %b inst %h expected 2 1 0", lat, icache_error_o, icache_inst_o);
      end
      tick();
      issue_and_wait(32'hFFFF_FFFF, 0, lat, acc);
      vectors++;
      if (lat !== 2 || icache_error_o !== 1'b1 || icache_inst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL oor_top: got lat %0d err %b inst %h expected 2 1 0", lat, icache_error_o, icache_inst_o);
      end
      vectors++;
      if (addr_log.size() !== n0 || rd_cycles !== r0) begin
         miscompares++;
         $display("FAIL oor_no_mem: got %0d read cycles expected 0", rd_cycles - r0);
      end
      tick();
      tick();
   endtask

   task automatic test_bus_error();
      int lat, acc, n0;
      n0 = addr_log.size();
      cfg_err[0] = 1'b1;
      issue_and_wait(32'h0000_0000, 0, lat, acc);
      cfg_err[0] = 1'b0;
      vectors++;
      if (lat !== 5 || icache_error_o !== 1'b1 || icache_inst_o !== 64'h00100093_00000013) begin
         miscompares++;
         $display("FAIL buserr_resp: got lat %0d err %b inst %h expected 5 1 00100093_00000013",
                  lat, icache_error_o, icache_inst_o);
      end
      vectors++;
      if (addr_log.size() !== n0 + 2 || addr_log[n0+1] !== 32'h4) begin
         miscompares++;
         $display("FAIL buserr_hi_read: got %0d reads expected 2 ending at 4", addr_log.size() - n0);
      end
      tick();
      issue_and_wait(32'h0000_0008, 0, lat, acc);
      vectors++;
      if (lat !== 5 || icache_error_o !== 1'b0) begin
         miscompares++;
         $display("FAIL buserr_clear: got lat %0d err %b expected 5 0", lat, icache_error_o);
      end
      tick();
      tick();
   endtask

   task automatic test_stall();
      int lat, acc_hi;
      lat = -1;
      acc_hi = 0;
      cfg_acc_stall[0] = 3;
      cfg_ack_delay[1] = 2;
      icache_rd_i = 1'b1;
      icache_pc_i = 32'h0000_0000;
      for (int k = 1; k <= 30; k++) begin
         tick();
         icache_rd_i = 1'b0;
         if (icache_valid_o) begin
            lat = k;
            break;
         end
         if (icache_accept_o) acc_hi++;
         if (k <= 4) begin
            vectors++;
            if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0) begin
               miscompares++;
               $display("FAIL stall_addr_c%0d: got rd %b addr %h expected 1 00000000", k, mem_rd_o, mem_addr_o);
            end
         end
      end
      cfg_acc_stall[0] = 0;
      cfg_ack_delay[1] = 0;
      vectors++;
      if (lat !== 10 || acc_hi !== 0) begin
         miscompares++;
         $display("FAIL stall_latency: got lat %0d accept-high %0d expected 10 0", lat, acc_hi);
      end
      vectors++;
      if (icache_inst_o !== 64'h00100093_00000013) begin
         miscompares++;
         $display("FAIL stall_data: got %h expected 00100093_00000013", icache_inst_o);
      end
      tick();
      tick();
   endtask

   task automatic test_flush();
      int lat, acc;
      issue_and_wait(32'h0000_0008, 2, lat, acc);
      vectors++;
      if (lat !== 5 || acc !== 0 || icache_inst_o !== 64'hFFF00113_00002083) begin
         miscompares++;
         $display("FAIL flush_inflight: got lat %0d acc %0d inst %h expected 5 0 FFF00113_00002083",
                  lat, acc, icache_inst_o);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses, lat, acc;
      pulses = 0;
      cfg_ack_delay[1] = 6;
      icache_rd_i = 1'b1;
      icache_pc_i = 32'h0000_0000;
      for (int k = 1; k <= 4; k++) begin
         tick();
         icache_rd_i = 1'b0;
         if (icache_valid_o) pulses++;
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      cfg_ack_delay[1] = 0;
      vectors++;
      if (icache_accept_o !== 1'b1 || icache_valid_o !== 1'b0 || mem_rd_o !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_idle: got accept %b valid %b rd %b expected 1 0 0",
                  icache_accept_o, icache_valid_o, mem_rd_o);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         if (icache_valid_o) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL midreset_no_resp: got %0d pulses expected 0", pulses);
      end
      issue_and_wait(32'h0000_0004, 0, lat, acc);
      vectors++;
      if (lat !== 5 || icache_inst_o !== 64'h00100093_00000013 || icache_error_o !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_recover: got lat %0d inst %h err %b expected 5 00100093_00000013 0",
                  lat, icache_inst_o, icache_error_o);
      end
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
      mem_arr[0]  = 32'h0000_0013;
      mem_arr[1]  = 32'h0010_0093;
      mem_arr[2]  = 32'h0000_2083;
      mem_arr[3]  = 32'hFFF0_0113;
      mem_arr[62] = 32'hCAFE_0001;
      mem_arr[63] = 32'hCAFE_0002;

      test_reset();
      test_basic();
      test_top_of_region();
      test_back_to_back();
      test_out_of_range();
      test_bus_error();
      test_stall();
      test_flush();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
